// File: rtl/bp_nexus_pkg.sv
// Shared types for the Nexus program-trace encoder: message codes, encoder
// FSM states and the message-code width used to pack FIFO entries.
package bp_nexus_pkg;

  localparam int unsigned MCODE_W = 2;

  typedef enum logic [1:0] {
    NEXUS_MCODE_COMPRESSED    = 2'd0,
    NEXUS_MCODE_DIRECT_BRANCH = 2'd1,
    NEXUS_MCODE_SYNC          = 2'd2,
    NEXUS_MCODE_OVERFLOW      = 2'd3
  } nexus_mcode_e;

  typedef enum logic [1:0] {
    ST_SYNC_PEND = 2'd0,
    ST_RUN       = 2'd1,
    ST_OVF       = 2'd2
  } enc_state_e;

endpackage

// File: rtl/bp_trace_msg_fifo.sv
// Output message FIFO: power-of-two ring buffer, push accepted when not full
// or when the head pops in the same cycle.
module bp_trace_msg_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_s, pop_s;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == {(AW + 1){1'b0}});
  assign out_data_o = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    pop_s    = !empty_o & out_ready_i;
    push_s   = in_valid_i & (!full_o | pop_s);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage cleared so the head reads zero out of reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bp_nexus_trace_encoder_p.sv
// Nexus program-trace encoder: turns retire-stream PC discontinuities into
// COMPRESSED / DIRECT_BRANCH messages with periodic SYNC and overflow recovery.
module bp_nexus_trace_encoder_p
  import bp_nexus_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned OFFSET_W    = 12,
  parameter int unsigned TS_W        = 16,
  parameter int unsigned INSN_BYTES  = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_PERIOD = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            enable_i,
  input  logic            commit_valid_i,
  input  logic [PC_W-1:0] commit_pc_i,
  output logic            trace_valid_o,
  input  logic            trace_ready_i,
  output logic [1:0]      trace_mcode_o,
  output logic [PC_W-1:0] trace_addr_o,
  output logic [TS_W-1:0] trace_ts_o,
  output logic            overflow_o
);

  localparam int unsigned MSG_W = MCODE_W + PC_W + TS_W;
  localparam int unsigned CNT_W = $clog2(SYNC_PERIOD + 1);
  localparam int unsigned HI_W  = PC_W - OFFSET_W + 1;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_PERIOD - 1);
  localparam logic [TS_W-1:0]  TS_MAX    = {TS_W{1'b1}};
  localparam logic [PC_W-1:0]  PC_INC    = PC_W'(INSN_BYTES);

  enc_state_e       state_q, state_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [TS_W-1:0]  ts_cnt_q, ts_cnt_d;
  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
  logic             overflow_q, overflow_d;

  logic             need_s, disc_s, fits_s, space_s, want_s, push_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [PC_W-1:0]  delta_s, msg_addr_s;
  logic [HI_W-1:0]  delta_hi_s;
  nexus_mcode_e     msg_mcode_s;
  logic [MSG_W-1:0] push_data_s, head_data_s;

  // Message selection, FSM next state and counter updates.
  always_comb begin
    need_s      = commit_valid_i & enable_i;
    delta_s     = commit_pc_i - last_pc_q;
    disc_s      = (commit_pc_i != (last_pc_q + PC_INC));
    // The offset fits when every bit above the sign bit matches it.
    delta_hi_s  = delta_s[PC_W-1:OFFSET_W-1];
    fits_s      = (delta_hi_s == {HI_W{1'b0}}) | (delta_hi_s == {HI_W{1'b1}});
    space_s     = !fifo_full_s | (!fifo_empty_s & trace_ready_i);
    want_s      = 1'b0;
    msg_mcode_s = NEXUS_MCODE_SYNC;
    msg_addr_s  = commit_pc_i;
    state_d     = state_q;
    overflow_d  = overflow_q;
    msg_cnt_d   = msg_cnt_q;

    case (state_q)
      ST_SYNC_PEND: begin
        if (need_s) begin
          want_s      = 1'b1;
          msg_mcode_s = NEXUS_MCODE_SYNC;
        end else begin
          want_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (need_s && (msg_cnt_q == SYNC_LAST)) begin
          want_s      = 1'b1;
          msg_mcode_s = NEXUS_MCODE_SYNC;
        end else if (need_s && disc_s) begin
          want_s = 1'b1;
          if (fits_s) begin
            msg_mcode_s = NEXUS_MCODE_COMPRESSED;
            msg_addr_s  = delta_s;
          end else begin
            msg_mcode_s = NEXUS_MCODE_DIRECT_BRANCH;
          end
        end else begin
          want_s = 1'b0;
        end
      end
      ST_OVF: begin
        if (space_s) begin
          want_s      = 1'b1;
          msg_mcode_s = NEXUS_MCODE_OVERFLOW;
          msg_addr_s  = last_pc_q;
        end else begin
          want_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_SYNC_PEND;
      end
    endcase

    push_s = want_s & space_s & enable_i;

    if (!enable_i) begin
      state_d = ST_SYNC_PEND;
    end else if (push_s) begin
      case (msg_mcode_s)
        NEXUS_MCODE_SYNC: begin
          state_d   = ST_RUN;
          msg_cnt_d = {CNT_W{1'b0}};
        end
        NEXUS_MCODE_OVERFLOW: begin
          state_d   = ST_SYNC_PEND;
          msg_cnt_d = msg_cnt_q + CNT_W'(1);
        end
        default: begin
          msg_cnt_d = msg_cnt_q + CNT_W'(1);
        end
      endcase
    end else if (want_s) begin
      overflow_d = 1'b1;
      state_d    = ST_OVF;
    end else begin
      state_d = state_q;
    end

    if (push_s) begin
      ts_cnt_d = TS_W'(1);
    end else if (ts_cnt_q == TS_MAX) begin
      ts_cnt_d = TS_MAX;
    end else begin
      ts_cnt_d = ts_cnt_q + TS_W'(1);
    end

    if (commit_valid_i) begin
      last_pc_d = commit_pc_i;
    end else begin
      last_pc_d = last_pc_q;
    end

    push_data_s = {msg_mcode_s, msg_addr_s, ts_cnt_q};
  end

  // Encoder state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_SYNC_PEND;
      last_pc_q  <= {PC_W{1'b0}};
      ts_cnt_q   <= {TS_W{1'b0}};
      msg_cnt_q  <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_pc_q  <= last_pc_d;
      ts_cnt_q   <= ts_cnt_d;
      msg_cnt_q  <= msg_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  bp_trace_msg_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (push_s),
    .in_data_i   (push_data_s),
    .out_ready_i (trace_ready_i),
    .out_data_o  (head_data_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  assign trace_valid_o = !fifo_empty_s;
  assign trace_mcode_o = head_data_s[MSG_W-1 -: MCODE_W];
  assign trace_addr_o  = head_data_s[TS_W +: PC_W];
  assign trace_ts_o    = head_data_s[TS_W-1:0];
  assign overflow_o    = overflow_q;

endmodule
